score_keeper: RTL

Producer side of the score display path: accumulates gameplay events (pellets, power pellets, ghost chains) into a saturating binary score. It tracks the session high score and converts both to packed BCD with a sequential double-dabble engine. Its BCD outputs feed the text overlay renderer, which turns digits into ASCII glyphs. It replaces the combinational binary-to-BCD path with a registered, multi-cycle converter that has a valid flag.

---
 rtl/score_keeper.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper: saturating game score and session high score, with a
// sequential double-dabble converter that publishes both as packed BCD.

package score_keeper_pkg;
  typedef enum logic [2:0] {
    GAME_MODE_IDLE    = 3'd0,
    GAME_MODE_LOADING = 3'd1,
    GAME_MODE_READY   = 3'd2,
    GAME_MODE_PLAYING = 3'd3,
    GAME_MODE_FAIL    = 3'd4
  } game_mode_t;
endpackage

module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH       = 16,
  parameter int unsigned BCD_DIGITS        = 4,
  parameter int unsigned SCORE_MAX         = 9999,
  parameter int unsigned PELLET_POINTS     = 10,
  parameter int unsigned POWER_POINTS      = 50,
  parameter int unsigned GHOST_BASE_POINTS = 200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  game_mode_t              MODE,
  input  logic                    pellet_eaten,
  input  logic                    power_eaten,
  input  logic                    ghost_eaten,
  output logic [SCORE_WIDTH-1:0]  score,
  output logic [SCORE_WIDTH-1:0]  high_score,
  output logic [4*BCD_DIGITS-1:0] bcd_score,
  output logic [4*BCD_DIGITS-1:0] bcd_high,
  output logic                    bcd_valid
);

  localparam int unsigned SUM_W = SCORE_WIDTH + 1;
  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = (SCORE_WIDTH > 1) ? $clog2(SCORE_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } conv_state_t;

  game_mode_t             mode_q;
  logic [1:0]             chain;
  logic [1:0]             chain_next_c;
  logic                   events_on_c;
  logic                   clear_c;
  logic [SUM_W-1:0]       chain_value_c;
  logic [SUM_W-1:0]       sum_c;
  logic [SCORE_WIDTH-1:0] score_next_c;

  // Event scoring: ghost uses the pre-update chain value; a READY entry clears all.
  always_comb begin
    events_on_c   = !(MODE inside {GAME_MODE_LOADING, GAME_MODE_READY, GAME_MODE_FAIL});
    clear_c       = (MODE == GAME_MODE_READY) && (mode_q != GAME_MODE_READY);
    chain_value_c = SUM_W'(GHOST_BASE_POINTS) << chain;
    sum_c         = SUM_W'(score);
    chain_next_c  = chain;
    if (events_on_c) begin
      if (pellet_eaten) sum_c = sum_c + SUM_W'(PELLET_POINTS);
      if (power_eaten)  sum_c = sum_c + SUM_W'(POWER_POINTS);
      if (ghost_eaten)  sum_c = sum_c + chain_value_c;
      if (power_eaten) begin
        chain_next_c = 2'd0;
      end else if (ghost_eaten && (chain != 2'd3)) begin
        chain_next_c = chain + 2'd1;
      end
    end
    score_next_c = (sum_c > SUM_W'(SCORE_MAX)) ? SCORE_WIDTH'(SCORE_MAX)
                                               : sum_c[SCORE_WIDTH-1:0];
    if (clear_c) begin
      score_next_c = '0;
      chain_next_c = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= GAME_MODE_LOADING;
      chain      <= 2'd0;
      score      <= '0;
      high_score <= '0;
    end else begin
      mode_q <= MODE;
      chain  <= chain_next_c;
      score  <= score_next_c;
      if (score > high_score) high_score <= score;
    end
  end

  conv_state_t            state;
  conv_state_t            state_next;
  logic [SCORE_WIDTH-1:0] snap_score;
  logic [SCORE_WIDTH-1:0] snap_high;
  logic [BCD_W-1:0]       sh_score;
  logic [BCD_W-1:0]       sh_high;
  logic [BCD_W-1:0]       sh_score_c;
  logic [BCD_W-1:0]       sh_high_c;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   mismatch_c;

  // One double-dabble step: correct every nibble >= 5, then shift in a bit.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] v,
                                               input logic            in_bit);
    logic [BCD_W-1:0] adj;
    adj = v;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], in_bit};
  endfunction

  always_comb begin
    mismatch_c = (score != snap_score) || (high_score != snap_high);
    sh_score_c = dabble(sh_score, snap_score[bit_cnt]);
    sh_high_c  = dabble(sh_high, snap_high[bit_cnt]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (mismatch_c) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == '0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Converter datapath; outputs are only written on the final shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_score <= '0;
      snap_high  <= '0;
      sh_score   <= '0;
      sh_high    <= '0;
      bit_cnt    <= '0;
      bcd_score  <= '0;
      bcd_high   <= '0;
      bcd_valid  <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: if (!mismatch_c) bcd_valid <= 1'b1;
        ST_LOAD: begin
          snap_score <= score;
          snap_high  <= high_score;
          sh_score   <= '0;
          sh_high    <= '0;
          bit_cnt    <= CNT_W'(SCORE_WIDTH - 1);
          bcd_valid  <= 1'b0;
        end
        ST_SHIFT: begin
          sh_score <= sh_score_c;
          sh_high  <= sh_high_c;
          bit_cnt  <= bit_cnt - CNT_W'(1);
          if (bit_cnt == '0) begin
            bcd_score <= sh_score_c;
            bcd_high  <= sh_high_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
